// File: rtl/rv32i_types.sv
// Shared RV32I core types: hazard-controller state, pipeline enable bundle,
// the NOP control word loaded into ID/EX on a bubble, and the load-use test.
package rv32i_types;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [1:0] {
        RFMUX_ALU = 2'd0,
        RFMUX_MEM = 2'd1,
        RFMUX_PC4 = 2'd2,
        RFMUX_IMM = 2'd3
    } regfilemux_sel_t;

    // Decoded control word carried in ID/EX; the datapath loads NOP_CTRL_WORD on a bubble.
    typedef struct packed {
        logic [3:0]      alu_op;
        logic            alu_a_pc;
        logic            alu_b_imm;
        logic            regf_we;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
        logic            br_en;
        logic            jmp_en;
        regfilemux_sel_t regfilemux_sel;
    } ctrl_word_t;

    localparam ctrl_word_t NOP_CTRL_WORD = '{
        alu_op:         4'd0,
        alu_a_pc:       1'b0,
        alu_b_imm:      1'b0,
        regf_we:        1'b0,
        mem_read:       1'b0,
        mem_write:      1'b0,
        funct3:         3'd0,
        br_en:          1'b0,
        jmp_en:         1'b0,
        regfilemux_sel: RFMUX_ALU
    };

    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic bubble_id_ex;
        logic flush_if_id;
        logic pcmux_br;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE = '{
        load_pc: 1'b0, load_if_id: 1'b0, load_id_ex: 1'b0, load_ex_mem: 1'b0,
        load_mem_wb: 1'b0, bubble_id_ex: 1'b0, flush_if_id: 1'b0, pcmux_br: 1'b0
    };

    localparam pipe_ctrl_t CTRL_ADVANCE = '{
        load_pc: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1, load_ex_mem: 1'b1,
        load_mem_wb: 1'b1, bubble_id_ex: 1'b0, flush_if_id: 1'b0, pcmux_br: 1'b0
    };

    // Hold PC and IF/ID, let the load move on and slip a NOP in behind it.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        load_pc: 1'b0, load_if_id: 1'b0, load_id_ex: 1'b1, load_ex_mem: 1'b1,
        load_mem_wb: 1'b1, bubble_id_ex: 1'b1, flush_if_id: 1'b0, pcmux_br: 1'b0
    };

    localparam pipe_ctrl_t CTRL_BRANCH = '{
        load_pc: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1, load_ex_mem: 1'b1,
        load_mem_wb: 1'b1, bubble_id_ex: 1'b1, flush_if_id: 1'b1, pcmux_br: 1'b1
    };

    function automatic logic load_use_hazard(
        input logic       ex_is_load,
        input logic [4:0] ex_rd,
        input logic [4:0] rs1,
        input logic       uses_rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return ex_is_load && (ex_rd != 5'd0) &&
               ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, cleared by rst.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the 5-stage RV32I core: cache-miss freezes, load-use
// bubbles and taken-branch flushes. Define HAZARD_PERF_EN for the perf counters.
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             icache_req,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             pcmux_br,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hz_state_dbg
);

    // Cache handshake: req stays high from the first cycle of an access until
    // the cycle resp pulses; resp in the first req cycle is a hit. Once a cache
    // has answered, its req may stay high until the advance and is ignored.
    hz_state_t  state_q, state_d;
    logic       i_done_q, i_done_d;
    logic       d_done_q, d_done_d;
    logic       i_hit, d_hit;
    logic       miss;
    logic       load_use;
    logic       advance;
    pipe_ctrl_t adv_ctrl;
    pipe_ctrl_t ctrl;

    assign i_hit = icache_req & icache_resp;
    assign d_hit = dcache_req & dcache_resp;
    assign miss  = (icache_req & ~icache_resp & ~i_done_q) |
                   (dcache_req & ~dcache_resp & ~d_done_q);

    assign load_use = load_use_hazard(ex_is_load, ex_rd, id_rs1, id_uses_rs1,
                                      id_rs2, id_uses_rs2);

    // A taken branch wins over load-use: the dependent instruction is wrong-path.
    always_comb begin
        adv_ctrl = CTRL_ADVANCE;
        if (ex_br_taken) begin
            adv_ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            adv_ctrl = CTRL_LOAD_USE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HZ_RUN;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        advance  = 1'b0;
        ctrl     = CTRL_FREEZE;
        if (!rst) begin
            case (state_q)
                HZ_RUN: begin
                    if (miss) begin
                        state_d  = HZ_WAIT;
                        i_done_d = i_done_q | i_hit;
                        d_done_d = d_done_q | d_hit;
                    end else begin
                        advance = 1'b1;
                    end
                end
                HZ_WAIT: begin
                    if (miss) begin
                        i_done_d = i_done_q | i_hit;
                        d_done_d = d_done_q | d_hit;
                    end else begin
                        state_d = HZ_RUN;
                        advance = 1'b1;
                    end
                end
                default: state_d = HZ_RUN;
            endcase
            if (advance) begin
                i_done_d = 1'b0;
                d_done_d = 1'b0;
                ctrl     = adv_ctrl;
            end
        end
    end

    assign load_pc      = ctrl.load_pc;
    assign load_if_id   = ctrl.load_if_id;
    assign load_id_ex   = ctrl.load_id_ex;
    assign load_ex_mem  = ctrl.load_ex_mem;
    assign load_mem_wb  = ctrl.load_mem_wb;
    assign bubble_id_ex = ctrl.bubble_id_ex;
    assign flush_if_id  = ctrl.flush_if_id;
    assign pcmux_br     = ctrl.pcmux_br;
    assign hz_state_dbg = ~rst & (state_q == HZ_WAIT);

`ifdef HAZARD_PERF_EN
    logic             frozen;
    logic             bubble_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

    assign frozen     = ~rst & miss;
    assign bubble_evt = advance & ~ex_br_taken & load_use;
    assign flush_evt  = advance & ex_br_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frozen),
        .count (stall_q)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_evt),
        .count (bubble_q)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_evt),
        .count (flush_q)
    );

    // Counters read as zero during reset, like every other output.
    assign stall_cnt  = rst ? '0 : stall_q;
    assign bubble_cnt = rst ? '0 : bubble_q;
    assign flush_cnt  = rst ? '0 : flush_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios with literal
// expectations, then randomized traffic checked every cycle against a rule model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int EW = 9 + 3 * CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken;
    logic             icache_req, icache_resp, dcache_req, dcache_resp;
    logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             bubble_id_ex, flush_if_id, pcmux_br, hz_state_dbg;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
    logic [7:0]       dut_ctrl;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .icache_req   (icache_req),
        .icache_resp  (icache_resp),
        .dcache_req   (dcache_req),
        .dcache_resp  (dcache_resp),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .pcmux_br     (pcmux_br),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt),
        .hz_state_dbg (hz_state_dbg)
    );

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble, flush, pcmux}
    assign dut_ctrl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                       bubble_id_ex, flush_if_id, pcmux_br};

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: "which caches are still owed an answer", previous-cycle
    // freeze, and plain event tallies.
    bit m_wait, m_seen_i, m_seen_d, m_adv;
    int m_stall, m_bubble, m_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        bit         hit;
        logic [4:0] src [2];
        bit         used [2];
        hit = 1'b0;
        src[0] = id_rs1;       src[1] = id_rs2;
        used[0] = id_uses_rs1; used[1] = id_uses_rs2;
        for (int s = 0; s < 2; s++)
            if (ex_is_load && ex_rd != 5'd0 && used[s] && src[s] == ex_rd) hit = 1'b1;
        return hit;
    endfunction

    function automatic bit model_waiting();
        bit i_owed, d_owed;
        i_owed = icache_req && !icache_resp && !m_seen_i;
        d_owed = dcache_req && !dcache_resp && !m_seen_d;
        return i_owed || d_owed;
    endfunction

    function automatic logic [7:0] model_ctrl();
        if (rst || model_waiting()) return 8'b0000_0000;
        if (ex_br_taken)            return 8'b1111_1111;
        if (model_load_use())       return 8'b0011_1100;
        return 8'b1111_1000;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_view(input int v);
        return (PERF && !rst) ? v[CNT_W-1:0] : '0;
    endfunction

    function automatic logic [31:0] pc(input int v);
        return PERF ? v : 0;
    endfunction

    // Compare at the falling edge, then step the model as the rising edge will.
    task automatic run_cycle();
        logic [EW-1:0] exp_w, act_w;
        bit            w;
        @(negedge clk);
        w = model_waiting();
        exp_w = {(rst ? 1'b0 : m_wait), model_ctrl(),
                 cnt_view(m_stall), cnt_view(m_bubble), cnt_view(m_flush)};
        exp_q.push_back(exp_w);
        act_w = {hz_state_dbg, dut_ctrl, stall_cnt, bubble_cnt, flush_cnt};
        check("cycle", act_w, exp_q.pop_front());
        m_adv = 1'b0;
        if (rst) begin
            m_wait = 0; m_seen_i = 0; m_seen_d = 0;
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else if (w) begin
            m_wait = 1;
            if (icache_req && icache_resp) m_seen_i = 1;
            if (dcache_req && dcache_resp) m_seen_d = 1;
            m_stall = sat_inc(m_stall);
        end else begin
            m_wait = 0; m_seen_i = 0; m_seen_d = 0; m_adv = 1;
            if (ex_br_taken)           m_flush  = sat_inc(m_flush);
            else if (model_load_use()) m_bubble = sat_inc(m_bubble);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_is_load = 0; ex_br_taken = 0;
        icache_req = 0; icache_resp = 0; dcache_req = 0; dcache_resp = 0;
    endtask

    bit ia, idn, da, ddn;
    int il, dl;

    initial begin
        rst = 1'b1;
        set_idle();
        run_cycle();
        check("rst_ctrl", dut_ctrl, 8'h00);
        check("rst_stall_cnt", stall_cnt, 0);
        next_edge();
        run_cycle();
        next_edge();
        rst = 1'b0;

        // load-use: lw x5 in EX, add reading x5 in ID
        set_idle(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        run_cycle(); check("lu_stall", dut_ctrl, 8'b0011_1100); next_edge();
        set_idle(); id_rs1 = 5; id_uses_rs1 = 1;
        run_cycle(); check("lu_release", dut_ctrl, 8'b1111_1000);
        check("lu_bubble_cnt", bubble_cnt, pc(1)); next_edge();

        // x0 destination and an unused matching source never stall
        set_idle(); ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        run_cycle(); check("x0_no_stall", dut_ctrl, 8'b1111_1000); next_edge();
        set_idle(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0;
        id_rs1 = 3; id_uses_rs1 = 1;
        run_cycle(); check("unused_rs2", dut_ctrl, 8'b1111_1000); next_edge();

        // taken branch overrides load-use
        set_idle(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_br_taken = 1;
        run_cycle(); check("br_over_lu", dut_ctrl, 8'b1111_1111); next_edge();
        set_idle();
        run_cycle(); check("br_flush_cnt", flush_cnt, pc(1));
        check("br_bubble_cnt", bubble_cnt, pc(1)); next_edge();

        // dual miss: icache answers in cycle 2, dcache in cycle 5
        for (int c = 0; c <= 5; c++) begin
            set_idle(); icache_req = 1; dcache_req = 1;
            icache_resp = (c == 2); dcache_resp = (c == 5);
            run_cycle();
            check((c == 5) ? "dual_advance" : "dual_freeze", dut_ctrl,
                  (c == 5) ? 8'b1111_1000 : 8'b0000_0000);
            check("dual_state", hz_state_dbg, (c == 0) ? 0 : 1);
            next_edge();
        end
        set_idle();
        run_cycle(); check("dual_stall_cnt", stall_cnt, pc(5));
        check("dual_back_run", hz_state_dbg, 0); next_edge();

        // branch held in EX across a 3-cycle dcache miss
        for (int c = 0; c <= 3; c++) begin
            set_idle(); dcache_req = 1; dcache_resp = (c == 3); ex_br_taken = 1;
            run_cycle();
            check((c == 3) ? "held_br_apply" : "held_br_freeze", dut_ctrl,
                  (c == 3) ? 8'b1111_1111 : 8'b0000_0000);
            next_edge();
        end
        set_idle();
        run_cycle(); check("held_flush_cnt", flush_cnt, pc(2));
        check("held_stall_cnt", stall_cnt, pc(8)); next_edge();

        // reset in the middle of a wait, then a late response
        set_idle(); icache_req = 1;
        run_cycle(); next_edge();
        run_cycle(); check("mid_wait_state", hz_state_dbg, 1); next_edge();
        rst = 1;
        run_cycle(); check("mid_wait_rst_ctrl", dut_ctrl, 8'h00); next_edge();
        rst = 0; set_idle(); icache_resp = 1;
        run_cycle(); check("late_resp_state", hz_state_dbg, 0);
        check("late_resp_stall_cnt", stall_cnt, 0);
        check("late_resp_ctrl", dut_ctrl, 8'b1111_1000); next_edge();
        set_idle(); icache_req = 1;
        run_cycle(); check("no_stale_done", dut_ctrl, 8'h00); next_edge();
        icache_resp = 1;
        run_cycle(); check("fresh_resp_adv", dut_ctrl, 8'b1111_1000); next_edge();

        // randomized traffic: accesses start only between advances
        ia = 0; idn = 0; da = 0; ddn = 0; il = 0; dl = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!ia && $urandom_range(0, 2) == 0) begin ia = 1; idn = 0; il = $urandom_range(0, 4); end
            if (!da && $urandom_range(0, 2) == 0) begin da = 1; ddn = 0; dl = $urandom_range(0, 4); end
            icache_req  = ia;
            icache_resp = ia && !idn && (il == 0);
            dcache_req  = da;
            dcache_resp = da && !ddn && (dl == 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_br_taken = ($urandom_range(0, 7) == 0);
            run_cycle();
            if (icache_resp) idn = 1; else if (ia && !idn && il > 0) il--;
            if (dcache_resp) ddn = 1; else if (da && !ddn && dl > 0) dl--;
            if (rst || m_adv) begin ia = 0; da = 0; end
            next_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
